axi4_lite_master: RTL

AXI4-Lite initiator, the counterpart of axi4_lite_slave. It turns single-beat local register requests into AXI4-Lite read and write transactions and returns the response data and status. Intended uses:
- Drive the accelerator control slave from simulation and self-test logic.
- Let fabric-side sequencers program other AXI4-Lite peripherals.

At most one transaction is outstanding at any time.

---
 rtl/axi4_lite_pkg.sv | 21 ++
 rtl/axi4_lite_master.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite initiator/target pair:
// FSM state encodings, response codes and the default protection value.
package axi4_lite_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD      = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] DEFAULT_PROT = 3'b010;

endpackage

// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: one local request at a time becomes one AXI4-Lite read or write.
// Optional watchdog enabled by defining AXI4_LITE_MASTER_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | ready for a local request
// WR      | AW and W offered, each drops after its own handshake
// WR_RESP | waiting for B
// RD      | AR offered
// RD_DATA | waiting for R
// DONE    | one-cycle resp_valid pulse
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int         C_M_AXI_ADDR_WIDTH = 32,
    parameter int         C_M_AXI_DATA_WIDTH = 32,
    parameter logic [2:0] C_PROT             = DEFAULT_PROT,
    parameter int         C_TIMEOUT_CYCLES   = 1024
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     req_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     req_data,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   req_strb,
    output logic                              resp_valid,
    output logic                              resp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     resp_data,
    output logic [1:0]                        resp_code,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int SW = C_M_AXI_DATA_WIDTH / 8;

    if ((C_M_AXI_DATA_WIDTH != 32 && C_M_AXI_DATA_WIDTH != 64) || C_TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("axi4_lite_master: data width must be 32 or 64 and timeout at least 1");
    end

    state_t                        state, state_nxt;
    logic                          aw_done, w_done, aw_done_nxt, w_done_nxt;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0] data_q;
    logic [SW-1:0]                 strb_q;
    logic                          busy, tmo_fire;

    assign busy = (state == WR) || (state == WR_RESP) || (state == RD) || (state == RD_DATA);

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(C_TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(C_TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_cnt;

    // Reloaded on every state change; terminal count means this is the last allowed cycle.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            tmo_cnt <= TMO_LOAD;
        end else if (state_nxt != state) begin
            tmo_cnt <= TMO_LOAD;
        end else if (busy && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    assign tmo_fire = busy && (tmo_cnt == '0);
`else
    assign tmo_fire = 1'b0;
`endif

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
        end
    end

    // A completing handshake takes priority over a watchdog expiring in the same cycle.
    always_comb begin
        state_nxt   = state;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        case (state)
            IDLE: begin
                aw_done_nxt = 1'b0;
                w_done_nxt  = 1'b0;
                if (req_valid) state_nxt = req_write ? WR : RD;
            end
            WR: begin
                aw_done_nxt = aw_done | M_AXI_AWREADY;
                w_done_nxt  = w_done | M_AXI_WREADY;
                if (aw_done_nxt && w_done_nxt) state_nxt = WR_RESP;
                else if (tmo_fire)             state_nxt = DONE;
            end
            WR_RESP: if (M_AXI_BVALID || tmo_fire) state_nxt = DONE;
            RD: begin
                if (M_AXI_ARREADY)  state_nxt = RD_DATA;
                else if (tmo_fire)  state_nxt = DONE;
            end
            RD_DATA: if (M_AXI_RVALID || tmo_fire) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            addr_q     <= '0;
            data_q     <= '0;
            strb_q     <= '0;
            resp_data  <= '0;
            resp_code  <= RESP_OKAY;
            resp_write <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                addr_q <= req_addr;
                data_q <= req_data;
                strb_q <= req_strb;
            end
            if (state == WR_RESP && M_AXI_BVALID) begin
                resp_data  <= '0;
                resp_code  <= M_AXI_BRESP;
                resp_write <= 1'b1;
            end else if (state == RD_DATA && M_AXI_RVALID) begin
                resp_data  <= M_AXI_RDATA;
                resp_code  <= M_AXI_RRESP;
                resp_write <= 1'b0;
            end else if (tmo_fire && !(state == RD && M_AXI_ARREADY)
                         && !(state == WR && aw_done_nxt && w_done_nxt)) begin
                resp_data  <= '0;
                resp_code  <= RESP_DECERR;
                resp_write <= (state == WR) || (state == WR_RESP);
            end
        end
    end

    assign req_ready     = (state == IDLE);
    assign resp_valid    = (state == DONE);
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = C_PROT;
    assign M_AXI_AWVALID = (state == WR) && !aw_done;
    assign M_AXI_WDATA   = data_q;
    assign M_AXI_WSTRB   = strb_q;
    assign M_AXI_WVALID  = (state == WR) && !w_done;
    assign M_AXI_BREADY  = (state == WR_RESP);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = C_PROT;
    assign M_AXI_ARVALID = (state == RD);
    assign M_AXI_RREADY  = (state == RD_DATA);

endmodule
